tausworth_checker: RTL and testbench
====================================

Name: tausworth_checker

Overview:
- Receive-side checker for the taus88 Tausworthe uniform generator stream (valid + 32-bit rand + error) feeding the randn datapath.
- Runs an independent taus88 model from the same seeds and compares it word-for-word with every valid sample.
- Counts words and mismatches, and latches the first failure for debug.
- Exports an 8-bit LED status word for board bring-up.

Parameters:
- DELAY, 1, simulation-only output assignment delay; no synthesis effect.
- SEED1, 32'd12345, initial s1 state; must be >1.
- SEED2, 32'd12345, initial s2 state; must be >7.
- SEED3, 32'd12345, initial s3 state; must be >15.
- MAX_ERR, 16'd255, mismatch count at which the checker enters FAIL.

Ports:
- CLK  in  1  sole clock.
- RESET_N  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous; restarts the model from the seeds and zeroes all counters and flags.
- valid  in  1  rand is a new generator word this cycle.
- rand  in  32  generator output word.
- gen_error  in  1  generator's own error flag.
- locked  out  1  at least one word seen and zero mismatches so far.
- mismatch  out  1  sticky; set on the first compare failure.
- err_count  out  16  mismatch count, saturating at 16'hFFFF.
- word_count  out  32  valid words checked, wraps modulo 2^32.
- first_bad_idx  out  32  word_count value at the first mismatch.
- first_bad_got  out  32  rand value at the first mismatch.
- fail  out  1  FSM is in FAIL.
- led  out  8  {gen_error_seen, fail, mismatch, locked, err_count[3:0]}.

Behaviour:
- Reset (RESET_N low, asynchronous): all outputs 0, gen_error_seen 0, model state = {SEED1,SEED2,SEED3}, FSM = IDLE.
- taus88 step, 32-bit unsigned, logical shifts:
  - s1' = ((s1&~1)<<12) ^ (((s1<<13)^s1)>>19)
  - s2' = ((s2&~7)<<4) ^ (((s2<<2)^s2)>>25)
  - s3' = ((s3&~15)<<17) ^ (((s3<<3)^s3)>>11)
  - expected = s1'^s2'^s3'
- The generator's first valid word after reset is defined as the output of the first step from the seeds. The model holds precomputed s', expected and advances exactly one step per valid cycle. valid low means the model holds.
- Compare latency: rand sampled at edge N; the comparison result appears on all outputs after edge N+1. Sample and compare are two registered stages; the model steps in the sample cycle, so back-to-back valid is supported at full rate.
- FSM:
  - IDLE: first compared word -> CHECK.
  - CHECK: err_count reaching MAX_ERR -> FAIL.
  - FAIL: counting continues and locked stays 0; leaves FAIL only via clear or reset.
- Per compared word:
  - word_count += 1.
  - Equal: no flag change; locked = (err_count==0).
  - Unequal: err_count += 1 (saturating); mismatch <= 1; locked <= 0.
  - If mismatch was previously 0, capture first_bad_idx = pre-increment word_count and first_bad_got = rand.
  - The model is not resynchronised on error: it keeps stepping, so a dropped word produces continuous mismatches.
- gen_error_seen: sticky OR of gen_error, sampled every cycle.
- clear:
  - Takes priority over valid in the same cycle; that valid word is discarded, not counted.
  - Restores the seeds, FSM = IDLE, all counters and flags 0, and flushes the compare stage.
  - A clear asserted while a word is in the compare stage discards that word.
- Reset mid-stream: everything returns to reset values immediately; the first post-reset word is compared against step 1.
- word_count wrap from FFFFFFFF to 0 has no side effects. err_count holds at FFFF.
- Outputs are registered; DELAY applies only to the led assignment.

Decomposition:
- Shared package/include: TRUE/FALSE macros (already in function.v); taus88 step constants (shift amounts 12/13/19, 4/2/25, 17/3/11; masks ~1/~7/~15); FSM state encodings IDLE=2'd0, CHECK=2'd1, FAIL=2'd2.
- One natural sub-module: taus88_step. It is combinational, takes {s1,s2,s3} and returns {s1',s2',s3',out}. The checker and the generator's bench model both use it.

Test Plan:
- Reset, then feed 1000 back-to-back words from the bench taus88 model -> word_count=1000, err_count=0, locked=1, mismatch=0, fail=0, led=8'b0001_0000.
- Same stream, but word 10 (index 9) XOR 32'h1 -> mismatch=1, err_count=1, first_bad_idx=9, first_bad_got=model word^1, locked=0, later words match.
- Drop word 5 of the stream -> mismatch from index 5 onward; err_count reaches 255, then fail=1, led[6]=1.
- Random valid gaps (valid ~30% duty) over 500 words -> err_count=0, word_count=500. Shows the model holds while valid is low.
- Assert clear together with valid on a corrupted word, then restart the stream from seed -> that word is not counted, all counters 0, the next 20 clean words give locked=1.
- Pulse gen_error for one cycle and drop RESET_N asynchronously mid-stream -> led[7]=1 before reset; all outputs 0 immediately on RESET_N low; stream restarted after release checks clean.

Source files
------------

// File: rtl/tausworth_checker_pkg.sv
// Shared definitions for the taus88 stream checker.
// Holds the taus88 shift/mask constants, the checker FSM state type and
// the packed three-word generator state.
package tausworth_checker_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // taus88 component 1
  localparam logic [31:0] S1_MASK  = 32'hFFFF_FFFE;
  localparam int unsigned S1_SHL_A = 12;
  localparam int unsigned S1_SHL_B = 13;
  localparam int unsigned S1_SHR   = 19;
  // taus88 component 2
  localparam logic [31:0] S2_MASK  = 32'hFFFF_FFF8;
  localparam int unsigned S2_SHL_A = 4;
  localparam int unsigned S2_SHL_B = 2;
  localparam int unsigned S2_SHR   = 25;
  // taus88 component 3
  localparam logic [31:0] S3_MASK  = 32'hFFFF_FFF0;
  localparam int unsigned S3_SHL_A = 17;
  localparam int unsigned S3_SHL_B = 3;
  localparam int unsigned S3_SHR   = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FAIL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] s3;
  } taus_state_t;

endpackage

// File: rtl/tausworth_checker_if.sv
// Generator-to-checker stream bundle.
//   valid     : rand_word carries a new generator word this cycle
//   rand_word : 32-bit generator output word
//   gen_error : generator's own error flag
// master = generator side, slave = checker side.
interface tausworth_checker_if;
  logic        valid;
  logic [31:0] rand_word;
  logic        gen_error;

  modport master (output valid, output rand_word, output gen_error);
  modport slave  (input  valid, input  rand_word, input  gen_error);
endinterface

// File: rtl/tausworth_checker_taus88_step.sv
// One combinational taus88 step.
//   s_i   : current {s1,s2,s3}
//   s_o   : next {s1',s2',s3'}
//   out_o : s1'^s2'^s3', the generator word produced by this step
module taus88_step
  import tausworth_checker_pkg::*;
(
  input  taus_state_t s_i,
  output taus_state_t s_o,
  output logic [31:0] out_o
);

  always_comb begin
    s_o.s1 = ((s_i.s1 & S1_MASK) << S1_SHL_A) ^ (((s_i.s1 << S1_SHL_B) ^ s_i.s1) >> S1_SHR);
    s_o.s2 = ((s_i.s2 & S2_MASK) << S2_SHL_A) ^ (((s_i.s2 << S2_SHL_B) ^ s_i.s2) >> S2_SHR);
    s_o.s3 = ((s_i.s3 & S3_MASK) << S3_SHL_A) ^ (((s_i.s3 << S3_SHL_B) ^ s_i.s3) >> S3_SHR);
    out_o  = s_o.s1 ^ s_o.s2 ^ s_o.s3;
  end

endmodule

// File: rtl/tausworth_checker.sv
// Receive-side checker for a taus88 generator stream.
// Runs its own taus88 model from the seeds, compares every valid word,
// counts words/mismatches, latches the first failure and drives a status LED word.
//   CLK, RESET_N (async, active low), clear (sync restart)
//   gen_if        : valid / rand_word / gen_error from the generator
//   locked        : >=1 word seen and no mismatches so far
//   mismatch      : sticky first-failure flag
//   err_count     : saturating mismatch count
//   word_count    : words compared, wraps
//   first_bad_idx : word_count at the first mismatch
//   first_bad_got : received word at the first mismatch
//   fail          : FSM in FAIL
//   led           : {gen_error_seen, fail, mismatch, locked, err_count[3:0]}
module tausworth_checker
  import tausworth_checker_pkg::*;
#(
  parameter int          DELAY   = 1,
  parameter logic [31:0] SEED1   = 32'd12345,
  parameter logic [31:0] SEED2   = 32'd12345,
  parameter logic [31:0] SEED3   = 32'd12345,
  parameter logic [15:0] MAX_ERR = 16'd255
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               clear,
  tausworth_checker_if.slave gen_if,
  output logic               locked,
  output logic               mismatch,
  output logic [15:0]        err_count,
  output logic [31:0]        word_count,
  output logic [31:0]        first_bad_idx,
  output logic [31:0]        first_bad_got,
  output logic               fail,
  output logic [7:0]         led
);

  localparam taus_state_t SEED_STATE = {SEED1, SEED2, SEED3};
  // DELAY has no hardware meaning; folded into a constant so overrides stay accepted.
  localparam logic [7:0] LED_KEEP = (DELAY >= 0) ? 8'hFF : 8'hFF;

  taus_state_t model_q, model_d, model_next;
  logic [31:0] model_out;

  logic        smp_vld_q, smp_vld_d;
  logic [31:0] smp_rand_q, smp_rand_d;
  logic [31:0] smp_exp_q, smp_exp_d;

  state_e      state_q, state_d;
  logic        locked_q, locked_d;
  logic        mismatch_q, mismatch_d;
  logic        gen_err_seen_q, gen_err_seen_d;
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] word_count_q, word_count_d;
  logic [31:0] first_bad_idx_q, first_bad_idx_d;
  logic [31:0] first_bad_got_q, first_bad_got_d;

  taus88_step u_step (
    .s_i   (model_q),
    .s_o   (model_next),
    .out_o (model_out)
  );

  always_comb begin
    model_d         = model_q;
    smp_vld_d       = FALSE;
    smp_rand_d      = smp_rand_q;
    smp_exp_d       = smp_exp_q;
    state_d         = state_q;
    locked_d        = locked_q;
    mismatch_d      = mismatch_q;
    err_count_d     = err_count_q;
    word_count_d    = word_count_q;
    first_bad_idx_d = first_bad_idx_q;
    first_bad_got_d = first_bad_got_q;
    gen_err_seen_d  = gen_err_seen_q | gen_if.gen_error;

    // Sample stage: the model steps here so the compare stage always holds
    // the expected word for the sampled one, allowing back-to-back valid.
    if (gen_if.valid) begin
      smp_vld_d  = TRUE;
      smp_rand_d = gen_if.rand_word;
      smp_exp_d  = model_out;
      model_d    = model_next;
    end

    // Compare stage
    if (smp_vld_q) begin
      word_count_d = word_count_q + 32'd1;
      if (smp_rand_q != smp_exp_q) begin
        if (err_count_q != '1) begin
          err_count_d = err_count_q + 16'd1;
        end
        mismatch_d = TRUE;
        if (!mismatch_q) begin
          first_bad_idx_d = word_count_q;
          first_bad_got_d = smp_rand_q;
        end
      end
      if (state_q != ST_FAIL) begin
        state_d = (err_count_d >= MAX_ERR) ? ST_FAIL : ST_CHECK;
      end
      locked_d = (err_count_d == '0) && (state_d != ST_FAIL);
    end

    // clear overrides both stages: the word being sampled and the word
    // being compared are both discarded.
    if (clear) begin
      model_d         = SEED_STATE;
      smp_vld_d       = FALSE;
      state_d         = ST_IDLE;
      locked_d        = FALSE;
      mismatch_d      = FALSE;
      err_count_d     = '0;
      word_count_d    = '0;
      first_bad_idx_d = '0;
      first_bad_got_d = '0;
      gen_err_seen_d  = FALSE;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      model_q         <= SEED_STATE;
      smp_vld_q       <= FALSE;
      smp_rand_q      <= '0;
      smp_exp_q       <= '0;
      state_q         <= ST_IDLE;
      locked_q        <= FALSE;
      mismatch_q      <= FALSE;
      err_count_q     <= '0;
      word_count_q    <= '0;
      first_bad_idx_q <= '0;
      first_bad_got_q <= '0;
      gen_err_seen_q  <= FALSE;
    end else begin
      model_q         <= model_d;
      smp_vld_q       <= smp_vld_d;
      smp_rand_q      <= smp_rand_d;
      smp_exp_q       <= smp_exp_d;
      state_q         <= state_d;
      locked_q        <= locked_d;
      mismatch_q      <= mismatch_d;
      err_count_q     <= err_count_d;
      word_count_q    <= word_count_d;
      first_bad_idx_q <= first_bad_idx_d;
      first_bad_got_q <= first_bad_got_d;
      gen_err_seen_q  <= gen_err_seen_d;
    end
  end

  assign locked        = locked_q;
  assign mismatch      = mismatch_q;
  assign err_count     = err_count_q;
  assign word_count    = word_count_q;
  assign first_bad_idx = first_bad_idx_q;
  assign first_bad_got = first_bad_got_q;
  assign fail          = (state_q == ST_FAIL);
  assign led           = {gen_err_seen_q, fail, mismatch_q, locked_q, err_count_q[3:0]} & LED_KEEP;

endmodule

// File: tb/tb_tausworth_checker.sv
// Self-checking bench for tausworth_checker: table-driven stream scenarios
// with a per-word scoreboard, plus hand-written clear and reset sequences.
module tb_tausworth_checker;

  localparam logic [95:0] SEEDS = {32'd12345, 32'd12345, 32'd12345};

  logic        clk;
  logic        RESET_N;
  logic        clear;
  logic        locked, mismatch, fail;
  logic [15:0] err_count;
  logic [31:0] word_count, first_bad_idx, first_bad_got;
  logic [7:0]  led;

  tausworth_checker_if gen_if ();

  tausworth_checker #(
    .DELAY   (1),
    .SEED1   (32'd12345),
    .SEED2   (32'd12345),
    .SEED3   (32'd12345),
    .MAX_ERR (16'd255)
  ) dut (
    .CLK           (clk),
    .RESET_N       (RESET_N),
    .clear         (clear),
    .gen_if        (gen_if),
    .locked        (locked),
    .mismatch      (mismatch),
    .err_count     (err_count),
    .word_count    (word_count),
    .first_bad_idx (first_bad_idx),
    .first_bad_got (first_bad_got),
    .fail          (fail),
    .led           (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference taus88 step, written out independently of the RTL.
  task automatic taus_step(input logic [95:0] s, output logic [95:0] sn, output logic [31:0] w);
    logic [31:0] a, b, c;
    a = s[95:64]; b = s[63:32]; c = s[31:0];
    a = ((a & 32'hFFFFFFFE) << 12) ^ (((a << 13) ^ a) >> 19);
    b = ((b & 32'hFFFFFFF8) << 4)  ^ (((b << 2)  ^ b) >> 25);
    c = ((c & 32'hFFFFFFF0) << 17) ^ (((c << 3)  ^ c) >> 11);
    sn = {a, b, c};
    w  = a ^ b ^ c;
  endtask

  // Scoreboard: expected checker outputs, due after the given clock edge.
  typedef struct {
    int unsigned due;
    logic [31:0] wc;
    logic [15:0] ec;
    logic        mm;
    logic        lk;
    logic        fl;
  } sb_t;
  sb_t sb[$];

  logic [95:0] gen_st, ref_st;
  logic [31:0] t_wc, t_fbi, t_fbg;
  logic [15:0] t_ec;
  logic        t_mm, t_fl, t_lk;

  task automatic restart_models();
    gen_st = SEEDS; ref_st = SEEDS;
    t_wc = 0; t_ec = 0; t_mm = 0; t_fl = 0; t_lk = 0; t_fbi = 0; t_fbg = 0;
    sb.delete();
  endtask

  task automatic track(input logic [31:0] w, input logic [31:0] rw);
    sb_t r;
    if (w != rw) begin
      if (t_ec != 16'hFFFF) t_ec = t_ec + 1;
      if (!t_mm) begin t_fbi = t_wc; t_fbg = w; end
      t_mm = 1;
    end
    t_wc = t_wc + 1;
    if (!t_fl && t_ec >= 16'd255) t_fl = 1;
    t_lk = (t_ec == 0) && !t_fl;
    r.due = edge_cnt + 2; r.wc = t_wc; r.ec = t_ec; r.mm = t_mm; r.lk = t_lk; r.fl = t_fl;
    sb.push_back(r);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
      sb_t r;
      r = sb.pop_front();
      chk("sb_word_count", word_count, r.wc);
      chk("sb_err_count",  {16'h0, err_count}, {16'h0, r.ec});
      chk("sb_mismatch",   {31'h0, mismatch}, {31'h0, r.mm});
      chk("sb_locked",     {31'h0, locked}, {31'h0, r.lk});
      chk("sb_fail",       {31'h0, fail}, {31'h0, r.fl});
    end
  end

  task automatic drive_stream(input int n, input int duty, input int corrupt,
                              input logic [31:0] cmask, input int drop);
    int sent = 0;
    int gen_idx = 0;
    logic [95:0] ns;
    logic [31:0] gw, rw, w;
    while (sent < n) begin
      @(negedge clk);
      if (duty >= 100 || $urandom_range(0, 99) < duty) begin
        taus_step(gen_st, ns, gw); gen_st = ns;
        if (gen_idx == drop) begin
          taus_step(gen_st, ns, gw); gen_st = ns;
          gen_idx++;
        end
        gen_idx++;
        w = (sent == corrupt) ? (gw ^ cmask) : gw;
        taus_step(ref_st, ns, rw); ref_st = ns;
        track(w, rw);
        gen_if.valid = 1'b1; gen_if.rand_word = w;
        sent++;
      end else begin
        gen_if.valid = 1'b0; gen_if.rand_word = $urandom;
      end
    end
    @(negedge clk);
    gen_if.valid = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1; gen_if.valid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("clear_word_count", word_count, 0);
    chk("clear_err_count", {16'h0, err_count}, 0);
    chk("clear_led", {24'h0, led}, 0);
    restart_models();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_locked"}, {31'h0, locked}, 0);
    chk({tag, "_mismatch"}, {31'h0, mismatch}, 0);
    chk({tag, "_err_count"}, {16'h0, err_count}, 0);
    chk({tag, "_word_count"}, word_count, 0);
    chk({tag, "_first_bad_idx"}, first_bad_idx, 0);
    chk({tag, "_first_bad_got"}, first_bad_got, 0);
    chk({tag, "_fail"}, {31'h0, fail}, 0);
    chk({tag, "_led"}, {24'h0, led}, 0);
  endtask

  typedef struct {
    string       name;
    int          n;
    int          duty;
    int          corrupt;
    logic [31:0] cmask;
    int          drop;
    logic [31:0] wc;
    logic [15:0] ec;
    logic        lk;
    logic        mm;
    logic        fl;
    logic [7:0]  led;
    logic [31:0] fbi;
  } vec_t;
  vec_t vecs[4];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [95:0] ns;
    logic [31:0] w;

    vecs[0] = '{name:"clean",   n:1000, duty:100, corrupt:-1, cmask:32'h0, drop:-1,
                wc:1000, ec:0,   lk:1, mm:0, fl:0, led:8'h10, fbi:0};
    vecs[1] = '{name:"flip9",   n:1000, duty:100, corrupt:9,  cmask:32'h1, drop:-1,
                wc:1000, ec:1,   lk:0, mm:1, fl:0, led:8'h21, fbi:9};
    vecs[2] = '{name:"drop5",   n:300,  duty:100, corrupt:-1, cmask:32'h0, drop:5,
                wc:300,  ec:295, lk:0, mm:1, fl:1, led:8'h67, fbi:5};
    vecs[3] = '{name:"gaps30",  n:500,  duty:30,  corrupt:-1, cmask:32'h0, drop:-1,
                wc:500,  ec:0,   lk:1, mm:0, fl:0, led:8'h10, fbi:0};

    RESET_N = 1'b0; clear = 1'b0;
    gen_if.valid = 1'b0; gen_if.rand_word = '0; gen_if.gen_error = 1'b0;
    restart_models();
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    RESET_N = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_clear();
      drive_stream(vecs[i].n, vecs[i].duty, vecs[i].corrupt, vecs[i].cmask, vecs[i].drop);
      drain();
      chk({vecs[i].name, "_word_count"}, word_count, vecs[i].wc);
      chk({vecs[i].name, "_err_count"}, {16'h0, err_count}, {16'h0, vecs[i].ec});
      chk({vecs[i].name, "_locked"}, {31'h0, locked}, {31'h0, vecs[i].lk});
      chk({vecs[i].name, "_mismatch"}, {31'h0, mismatch}, {31'h0, vecs[i].mm});
      chk({vecs[i].name, "_fail"}, {31'h0, fail}, {31'h0, vecs[i].fl});
      chk({vecs[i].name, "_led"}, {24'h0, led}, {24'h0, vecs[i].led});
      chk({vecs[i].name, "_first_bad_idx"}, first_bad_idx, vecs[i].fbi);
      chk({vecs[i].name, "_first_bad_got"}, first_bad_got, t_fbg);
    end

    // clear coincident with a corrupted valid word while another word sits
    // in the compare stage: nothing of either may be counted.
    do_clear();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      taus_step(gen_st, ns, w); gen_st = ns;
      gen_if.valid = 1'b1; gen_if.rand_word = w;
    end
    @(negedge clk);
    taus_step(gen_st, ns, w); gen_st = ns;
    gen_if.valid = 1'b1; gen_if.rand_word = w ^ 32'hDEAD_BEEF; clear = 1'b1;
    @(negedge clk);
    gen_if.valid = 1'b0; clear = 1'b0;
    #1;
    check_zero("clrv");
    @(negedge clk);
    #1;
    chk("clrv_late_word_count", word_count, 0);
    restart_models();
    drive_stream(20, 100, -1, 32'h0, -1);
    drain();
    chk("clrv_restart_word_count", word_count, 20);
    chk("clrv_restart_locked", {31'h0, locked}, 1);
    chk("clrv_restart_err_count", {16'h0, err_count}, 0);

    // gen_error pulse, then asynchronous reset in the middle of a stream.
    @(negedge clk);
    gen_if.gen_error = 1'b1;
    @(negedge clk);
    gen_if.gen_error = 1'b0;
    #1;
    chk("generr_led", {24'h0, led}, 32'h90);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      taus_step(gen_st, ns, w); gen_st = ns;
      gen_if.valid = 1'b1; gen_if.rand_word = w;
    end
    #2;
    RESET_N = 1'b0;
    sb.delete();
    #1;
    check_zero("async_rst");
    @(negedge clk);
    gen_if.valid = 1'b0;
    @(negedge clk);
    RESET_N = 1'b1;
    restart_models();
    drive_stream(50, 100, -1, 32'h0, -1);
    drain();
    chk("post_rst_word_count", word_count, 50);
    chk("post_rst_err_count", {16'h0, err_count}, 0);
    chk("post_rst_locked", {31'h0, locked}, 1);
    chk("post_rst_led", {24'h0, led}, 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
